branch_condition_evaluator: RTL and testbench

BRANCH_CONDITION_EVALUATOR -- requirements
Module: branch_condition_evaluator

---
 rtl/branch_condition_evaluator.sv | 104 ++++++++++
 tb/tb_branch_condition_evaluator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/branch_condition_evaluator.sv
// Per-thread branch predicate unit for a barrel-threaded core.
// Evaluates one thread's entry per cycle and registers the decision.
module branch_condition_evaluator #(
    parameter int PC_WIDTH       = 10,
    parameter int THREAD_COUNT   = 8,
    parameter int THREAD_WIDTH   = 3,
    parameter int COND_WIDTH     = 8,
    parameter int COND_SEL_WIDTH = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [PC_WIDTH-1:0]       pc,
    input  logic [COND_WIDTH-1:0]     flags,
    input  logic                      cfg_wren,
    input  logic [THREAD_WIDTH-1:0]   cfg_thread,
    input  logic [PC_WIDTH-1:0]       cfg_origin,
    input  logic [PC_WIDTH-1:0]       cfg_destination,
    input  logic [COND_SEL_WIDTH-1:0] cfg_cond_sel,
    input  logic                      cfg_enable,
    output logic                      jump,
    output logic [PC_WIDTH-1:0]       jump_destination,
    output logic [THREAD_WIDTH-1:0]   jump_thread
);

    localparam logic [THREAD_WIDTH-1:0] LAST_THREAD = THREAD_WIDTH'(THREAD_COUNT - 1);

    typedef struct packed {
        logic [PC_WIDTH-1:0]       origin;
        logic [PC_WIDTH-1:0]       destination;
        logic [COND_SEL_WIDTH-1:0] cond_sel;
        logic                      enable;
    } entry_t;

    entry_t                    entry_q [THREAD_COUNT];
    entry_t                    entry_d [THREAD_COUNT];
    logic [THREAD_WIDTH-1:0]   thread_q;
    logic [THREAD_WIDTH-1:0]   thread_d;
    logic                      jump_q;
    logic                      jump_d;
    logic [PC_WIDTH-1:0]       jump_destination_q;
    logic [PC_WIDTH-1:0]       jump_destination_d;
    logic [THREAD_WIDTH-1:0]   jump_thread_q;
    logic [THREAD_WIDTH-1:0]   jump_thread_d;

    entry_t                    cur_entry;
    logic [COND_WIDTH-1:0]     cond_vec;
    logic                      taken;

    // The always and constant-low positions are pinned here so that stray
    // upstream bits can never turn an unconditional or never-taken entry around.
    always_comb begin
        cond_vec    = flags;
        cond_vec[0] = 1'b1;
        cond_vec[5] = 1'b0;
        cond_vec[6] = 1'b0;
    end

    assign cur_entry = entry_q[thread_q];
    assign taken     = cur_entry.enable
                     && (pc == cur_entry.origin)
                     && cond_vec[cur_entry.cond_sel];

    always_comb begin
        thread_d           = (thread_q == LAST_THREAD) ? '0 : thread_q + 1'b1;
        jump_d             = taken;
        jump_destination_d = taken ? cur_entry.destination : '0;
        jump_thread_d      = thread_q;
    end

    // Evaluation above reads entry_q, so a write landing on the evaluating
    // thread only takes effect for that thread's next slot.
    always_comb begin
        entry_d = entry_q;
        if (cfg_wren && (cfg_thread <= LAST_THREAD)) begin
            entry_d[cfg_thread].origin      = cfg_origin;
            entry_d[cfg_thread].destination = cfg_destination;
            entry_d[cfg_thread].cond_sel    = cfg_cond_sel;
            entry_d[cfg_thread].enable      = cfg_enable;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            thread_q           <= '0;
            jump_q             <= 1'b0;
            jump_destination_q <= '0;
            jump_thread_q      <= '0;
            for (int i = 0; i < THREAD_COUNT; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            thread_q           <= thread_d;
            jump_q             <= jump_d;
            jump_destination_q <= jump_destination_d;
            jump_thread_q      <= jump_thread_d;
            entry_q            <= entry_d;
        end
    end

    assign jump             = jump_q;
    assign jump_destination = jump_destination_q;
    assign jump_thread      = jump_thread_q;

endmodule

// File: tb/tb_branch_condition_evaluator.sv
// Bench for branch_condition_evaluator: directed scenarios followed by random
// traffic, all checked against a slot-level behavioural model.
module tb_branch_condition_evaluator;

    logic       clock;
    logic       reset;
    logic [9:0] pc;
    logic [7:0] flags;
    logic       cfg_wren;
    logic [2:0] cfg_thread;
    logic [9:0] cfg_origin;
    logic [9:0] cfg_destination;
    logic [2:0] cfg_cond_sel;
    logic       cfg_enable;
    logic       jump;
    logic [9:0] jump_destination;
    logic [2:0] jump_thread;

    int checks = 0;
    int errors = 0;

    // Behavioural model: one record per thread plus the slot number.
    logic [9:0] m_origin [8];
    logic [9:0] m_dest   [8];
    logic [2:0] m_sel    [8];
    logic       m_en     [8];
    int         m_slot = 0;

    branch_condition_evaluator dut (
        .clock(clock),
        .reset(reset),
        .pc(pc),
        .flags(flags),
        .cfg_wren(cfg_wren),
        .cfg_thread(cfg_thread),
        .cfg_origin(cfg_origin),
        .cfg_destination(cfg_destination),
        .cfg_cond_sel(cfg_cond_sel),
        .cfg_enable(cfg_enable),
        .jump(jump),
        .jump_destination(jump_destination),
        .jump_thread(jump_thread)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic cond_true(input logic [2:0] sel, input logic [7:0] f);
        case (sel)
            3'd0:    return 1'b1;   // always
            3'd1:    return f[1];   // zero
            3'd2:    return f[2];   // non-zero
            3'd3:    return f[3];   // positive
            3'd4:    return f[4];   // negative
            3'd7:    return f[7];   // even
            default: return 1'b0;   // constant-low slots
        endcase
    endfunction

    task automatic step(input logic rst, input logic [9:0] p, input logic [7:0] f,
                        input logic we, input logic [2:0] ct, input logic [9:0] co,
                        input logic [9:0] cd, input logic [2:0] cs, input logic ce,
                        input string tag);
        logic       e_jump;
        logic [9:0] e_dest;
        logic [2:0] e_thread;
        int         t;
        reset = rst; pc = p; flags = f;
        cfg_wren = we; cfg_thread = ct; cfg_origin = co;
        cfg_destination = cd; cfg_cond_sel = cs; cfg_enable = ce;
        if (rst) begin
            e_jump = 1'b0; e_dest = '0; e_thread = '0;
            for (int i = 0; i < 8; i++) begin
                m_origin[i] = '0; m_dest[i] = '0; m_sel[i] = '0; m_en[i] = 1'b0;
            end
            m_slot = 0;
        end else begin
            t        = m_slot;
            e_jump   = m_en[t] && (p == m_origin[t]) && cond_true(m_sel[t], f);
            e_dest   = e_jump ? m_dest[t] : 10'd0;
            e_thread = 3'(t);
            if (we) begin
                m_origin[ct] = co; m_dest[ct] = cd; m_sel[ct] = cs; m_en[ct] = ce;
            end
            m_slot = (m_slot + 1) % 8;
        end
        @(posedge clock);
        #1;
        checks++;
        assert (jump === e_jump) else begin
            errors++;
            $error("FAIL %s jump: got %b expected %b", tag, jump, e_jump);
        end
        checks++;
        assert (jump_destination === e_dest) else begin
            errors++;
            $error("FAIL %s jump_destination: got %h expected %h", tag, jump_destination, e_dest);
        end
        checks++;
        assert (jump_thread === e_thread) else begin
            errors++;
            $error("FAIL %s jump_thread: got %0d expected %0d", tag, jump_thread, e_thread);
        end
    endtask

    task automatic idle(input logic [9:0] p, input logic [7:0] f, input string tag);
        step(1'b0, p, f, 1'b0, 3'd0, 10'd0, 10'd0, 3'd0, 1'b0, tag);
    endtask

    task automatic write(input logic [2:0] ct, input logic [9:0] co, input logic [9:0] cd,
                         input logic [2:0] cs, input logic ce, input string tag);
        step(1'b0, 10'h3FF, 8'h00, 1'b1, ct, co, cd, cs, ce, tag);
    endtask

    // Idles until the model's next slot belongs to thread t (at most 7 cycles).
    task automatic goto_slot(input int t, input logic [9:0] p, input logic [7:0] f, input string tag);
        for (int k = 0; k < 8 && m_slot != t; k++) idle(p, f, tag);
    endtask

    initial begin
        reset = 1'b1; pc = '0; flags = '0; cfg_wren = 1'b0; cfg_thread = '0;
        cfg_origin = '0; cfg_destination = '0; cfg_cond_sel = '0; cfg_enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_origin[i] = '0; m_dest[i] = '0; m_sel[i] = '0; m_en[i] = 1'b0;
        end

        // Reset, including a config write that must be dropped.
        step(1'b1, 10'h000, 8'hFF, 1'b0, 3'd0, 10'd0, 10'd0, 3'd0, 1'b0, "reset0");
        step(1'b1, 10'h000, 8'hFF, 1'b1, 3'd0, 10'h000, 10'h155, 3'd0, 1'b1, "reset_wr");
        for (int k = 0; k < 8; k++) idle(10'h000, 8'hFF, "post_reset");

        // Unconditional branch on thread 2; other threads see the same pc.
        write(3'd2, 10'h010, 10'h200, 3'd0, 1'b1, "wr_t2");
        for (int k = 0; k < 16; k++) idle(10'h010, 8'($urandom_range(0, 255)), "uncond");

        // Non-zero predicate on thread 5.
        write(3'd5, 10'h033, 10'h100, 3'd2, 1'b1, "wr_t5");
        goto_slot(5, 10'h000, 8'h00, "seek5");
        idle(10'h033, 8'h03, "t5_zero");
        goto_slot(5, 10'h000, 8'h00, "seek5b");
        idle(10'h033, 8'h05, "t5_nonzero");

        // Constant-low selects never jump, even with every flag bit high.
        write(3'd1, 10'h0AA, 10'h0BB, 3'd6, 1'b1, "wr_t1_sel6");
        goto_slot(1, 10'h000, 8'h00, "seek1");
        idle(10'h0AA, 8'hFF, "t1_sel6");
        write(3'd1, 10'h0AA, 10'h0BB, 3'd5, 1'b1, "wr_t1_sel5");
        goto_slot(1, 10'h000, 8'h00, "seek1b");
        idle(10'h0AA, 8'hFF, "t1_sel5");

        // Rewrite coinciding with the thread's own evaluation.
        write(3'd3, 10'h020, 10'h123, 3'd0, 1'b1, "wr_t3");
        goto_slot(3, 10'h000, 8'h00, "seek3");
        step(1'b0, 10'h020, 8'h01, 1'b1, 3'd3, 10'h040, 10'h123, 3'd0, 1'b1, "t3_old_origin");
        goto_slot(3, 10'h000, 8'h00, "seek3b");
        idle(10'h020, 8'h01, "t3_new_origin");

        // Mid-operation reset on thread 6's slot with a matching entry.
        write(3'd6, 10'h066, 10'h3C0, 3'd0, 1'b1, "wr_t6");
        goto_slot(6, 10'h066, 8'h01, "seek6");
        step(1'b1, 10'h066, 8'h01, 1'b0, 3'd0, 10'd0, 10'd0, 3'd0, 1'b0, "reset_mid");
        for (int k = 0; k < 8; k++) idle(10'h066, 8'h01, "after_reset_mid");

        // Free-running counter with wrap-around.
        for (int k = 0; k < 24; k++) idle(10'($urandom_range(0, 1023)), 8'($urandom), "free_run");

        // Random traffic over a narrow pc range so matches are frequent.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 59) == 0),
                 10'($urandom_range(0, 7)),
                 8'($urandom),
                 ($urandom_range(0, 3) == 0),
                 3'($urandom_range(0, 7)),
                 10'($urandom_range(0, 7)),
                 10'($urandom_range(0, 1023)),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0),
                 "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
